jimmy_port_capture: RTL and testbench
=====================================

Name: jimmy_port_capture

Overview:
Synthesizable, parametrised capture unit for the Jimmy CPU output ports. It generalises the bench-side "latch out_port on strobe falling edge, bump the input stimulus" pattern to NUM_CH channels, with a shared capture FIFO and overflow reporting. It sits beside the jimmy core on the same clock, watching out_strobe and out_port buses. It drives an auto-incrementing stimulus value onto a core input port.

Parameters:
DATA_W, 8, width of each output port and of in_port.
NUM_CH, 4, number of strobe/port channels captured.
FIFO_DEPTH, 16, capture FIFO entries; power of two, at least 2.
STIM_CH, 1, channel whose accepted captures advance in_port.
STIM_INIT, 0, reset value of in_port.
INC_STEP, 1, amount added to in_port per accepted STIM_CH capture.

Ports:
jimmy_clk  in  1  sole clock; all logic is on the rising edge.
reset  in  1  asynchronous, active-low reset.
out_strobe  in  NUM_CH  per-channel write strobes from the core; high while a port write is active.
out_port  in  NUM_CH*DATA_W  channel c data is bits [c*DATA_W +: DATA_W].
ch_enable  in  NUM_CH  capture enable per channel.
in_port  out  DATA_W  stimulus value to the core input port.
rd_en  in  1  pop request.
rd_valid  out  1  FIFO non-empty; rd_data is valid.
rd_data  out  clog2(NUM_CH)+DATA_W  show-ahead head entry, {channel, data}.
fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy.
overflow  out  1  sticky drop flag.
clr_overflow  in  1  synchronous clear for overflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - in_port=STIM_INIT.
  - FIFO empty: rd_valid=0, fifo_count=0, rd_data=0.
  - overflow=0.
  - Strobe history, hold registers and pending bits all 0.
- Hold register per channel:
  - While out_strobe[c]=1, hold[c] <= out_port slice c every cycle.
  - hold[c] therefore holds the data from the last high cycle.
- Falling-edge detect:
  - fall[c] = prev_strobe[c] & ~out_strobe[c], with prev_strobe registered each cycle.
  - On edge N with fall[c] and ch_enable[c], set pending[c] and copy hold[c] into pdata[c].
  - Disabled channels never set pending.
- Re-trigger: a fall on channel c while pending[c] is still set overwrites pdata[c] and sets overflow. The old value is lost.
- Arbitration:
  - Each cycle, the lowest-index pending channel is pushed as {c, pdata[c]} and its pending bit is cleared.
  - At most one push per cycle.
  - A lone fall at edge N is pushed at edge N+1; rd_valid=1 after edge N+1.
  - Simultaneous falls on k channels drain over k consecutive cycles in ascending index order.
- Push when full:
  - If full with no pop in the same cycle, the entry is dropped, pending is still cleared, and overflow=1.
  - If full with a pop in the same cycle, the push is accepted and the count is unchanged.
- Pop:
  - rd_en & rd_valid pops at the edge; rd_data shows the next entry after that edge.
  - rd_en while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop on an empty FIFO: only the push takes effect.
- Stimulus:
  - On each accepted push whose channel is STIM_CH, in_port <= in_port + INC_STEP, modulo 2^DATA_W.
  - Dropped entries do not advance in_port.
- Overflow:
  - overflow is cleared by clr_overflow=1 at the edge.
  - If a set event and clr_overflow occur in the same cycle, set wins.
- Reset mid-operation discards pending entries and FIFO contents immediately, with no partial pushes.
- An out_strobe pulse of one cycle is valid: hold captures it and the next cycle falls.

Test Plan:
- Reset release, ch_enable=4'hF: strobe[1] high for 2 cycles with port1=8'h05, then low → one entry {1,8'h05}, rd_valid=1 exactly one cycle after the fall, in_port=1.
- Falls on channels 3, 0 and 2 in the same cycle (data 8'h33, 8'h00, 8'h22) → entries pop in order {0,00}, {2,22}, {3,33}, fifo_count peaks at 3, in_port unchanged.
- 17 channel-1 writes with data 1..17 and no reads (depth 16) → fifo_count=16, overflow=1, in_port=16, head=1. Assert clr_overflow → overflow=0.
- FIFO full, push and pop in the same cycle → fifo_count stays 16, overflow stays 0, the new entry is last.
- ch_enable[1]=0, strobe[1] pulses → no entry and in_port unchanged. Then assert reset mid-drain with 3 entries queued → rd_valid=0, fifo_count=0, in_port=STIM_INIT immediately.
- in_port at 8'hFF with INC_STEP=1, one STIM_CH capture → in_port wraps to 8'h00.

Source files
------------

// File: rtl/jimmy_port_capture.sv
`default_nettype none
// jimmy_port_capture: captures each channel's last strobed port value on the strobe falling edge into a
// shared show-ahead FIFO, with sticky overflow and an auto-incrementing stimulus port. Rev 1.0
module jimmy_port_capture #(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int STIM_CH    = 1,
  parameter int STIM_INIT  = 0,
  parameter int INC_STEP   = 1,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int CNT_W     = AW + 1,
  localparam int ENT_W     = CH_W + DATA_W
) (
  input  logic                     jimmy_clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        out_strobe,
  input  logic [NUM_CH*DATA_W-1:0] out_port,
  input  logic [NUM_CH-1:0]        ch_enable,
  output logic [DATA_W-1:0]        in_port,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [ENT_W-1:0]         rd_data,
  output logic [CNT_W-1:0]         fifo_count,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [DATA_W-1:0] hold_q  [NUM_CH];
  logic [DATA_W-1:0] pdata_q [NUM_CH];
  logic [ENT_W-1:0]  mem_q   [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] in_port_q, in_port_d;
  logic              ovf_q, ovf_d;

  logic [NUM_CH-1:0] fall, cap, retrig, gnt_oh;
  logic [CH_W-1:0]   gnt_ch;
  logic              push_req, full, pop, accept, drop;

  assign fall     = prev_q & ~out_strobe;
  assign cap      = fall & ch_enable;
  assign push_req = |pend_q;
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop      = rd_en & (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign accept   = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    gnt_ch = '0;
    gnt_oh = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (pend_q[c]) gnt_ch = CH_W'(c);
    end
    if (push_req) gnt_oh[gnt_ch] = 1'b1;
  end

  // The channel being drained this cycle does not count as a lost re-trigger.
  assign retrig = cap & pend_q & ~gnt_oh;
  assign pend_d = (pend_q & ~gnt_oh) | cap;

  always_comb begin
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (drop || (|retrig)) ovf_d = 1'b1;
    else if (clr_overflow) ovf_d = 1'b0;
    in_port_d = in_port_q;
    if (accept && (gnt_ch == CH_W'(STIM_CH))) in_port_d = in_port_q + DATA_W'(INC_STEP);
  end

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      always_ff @(posedge jimmy_clk or negedge reset) begin
        if (!reset) begin
          hold_q[c]  <= '0;
          pdata_q[c] <= '0;
        end else begin
          if (out_strobe[c]) hold_q[c] <= out_port[c*DATA_W +: DATA_W];
          if (cap[c])        pdata_q[c] <= hold_q[c];
        end
      end
    end
  endgenerate

  always_ff @(posedge jimmy_clk or negedge reset) begin
    if (!reset) begin
      prev_q    <= '0;
      pend_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      in_port_q <= DATA_W'(STIM_INIT);
      ovf_q     <= 1'b0;
    end else begin
      prev_q    <= out_strobe;
      pend_q    <= pend_d;
      count_q   <= count_d;
      in_port_q <= in_port_d;
      ovf_q     <= ovf_d;
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the output is masked whenever the FIFO is empty.
  always_ff @(posedge jimmy_clk) begin
    if (accept) mem_q[wr_ptr_q] <= {gnt_ch, pdata_q[gnt_ch]};
  end

  assign rd_valid   = (count_q != '0);
  assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count = count_q;
  assign in_port    = in_port_q;
  assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_jimmy_port_capture.sv
`default_nettype none
// tb_jimmy_port_capture: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_jimmy_port_capture;

  localparam int DEPTH = 16;

  logic        clk;
  logic        reset;
  logic [3:0]  out_strobe;
  logic [31:0] out_port;
  logic [3:0]  ch_enable;
  logic [7:0]  in_port;
  logic        rd_en;
  logic        rd_valid;
  logic [9:0]  rd_data;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic        clr_overflow;

  int checks   = 0;
  int failures = 0;

  jimmy_port_capture dut (
    .jimmy_clk   (clk),
    .reset       (reset),
    .out_strobe  (out_strobe),
    .out_port    (out_port),
    .ch_enable   (ch_enable),
    .in_port     (in_port),
    .rd_en       (rd_en),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-channel "latched value waiting" slots and a queue of expected FIFO entries.
  logic [3:0] m_prev, m_pend;
  logic [7:0] m_hold  [4];
  logic [7:0] m_pdata [4];
  logic [9:0] exp_q [$];
  logic [7:0] m_in;
  logic       m_ovf;
  int         m_g;
  bit         m_set;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_prev = '0;
    m_pend = '0;
    for (int c = 0; c < 4; c++) begin
      m_hold[c]  = '0;
      m_pdata[c] = '0;
    end
    exp_q.delete();
    m_in  = 8'h00;
    m_ovf = 1'b0;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_set = 1'b0;
      m_g   = -1;
      for (int c = 3; c >= 0; c--) if (m_pend[c]) m_g = c;
      if (rd_en && exp_q.size() > 0) void'(exp_q.pop_front());
      if (m_g >= 0) begin
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back({m_g[1:0], m_pdata[m_g]});
          if (m_g == 1) m_in = m_in + 8'd1;
        end else begin
          m_set = 1'b1;
        end
        m_pend[m_g] = 1'b0;
      end
      for (int c = 0; c < 4; c++) begin
        if (m_prev[c] && !out_strobe[c] && ch_enable[c]) begin
          if (m_pend[c]) m_set = 1'b1;
          m_pend[c]  = 1'b1;
          m_pdata[c] = m_hold[c];
        end
        if (out_strobe[c]) m_hold[c] = out_port[c*8 +: 8];
        m_prev[c] = out_strobe[c];
      end
      if (m_set) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
    end
  end

  // Monitor: compares the presented head and status against the model after every edge.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      chk("count", 32'(fifo_count), 32'(exp_q.size()));
      chk("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
      if (rd_valid) chk("head", 32'(rd_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'hFFFF_FFFF);
      else          chk("empty_data", 32'(rd_data), 32'h0);
      chk("in_port", 32'(in_port), 32'(m_in));
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic step(input logic [3:0] st, input logic [31:0] pt, input logic rd, input logic clr);
    out_strobe   = st;
    out_port     = pt;
    rd_en        = rd;
    clr_overflow = clr;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rd);
    repeat (n) step(4'b0000, 32'h0, rd, 1'b0);
  endtask

  task automatic pulse1(input logic [7:0] d, input logic rd);
    step(4'b0010, {16'h0, d, 8'h0}, rd, 1'b0);
    step(4'b0000, 32'h0, rd, 1'b0);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    m_reset();
    #1;
    chk("rst_valid", 32'(rd_valid), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    chk("rst_data", 32'(rd_data), 32'h0);
    chk("rst_in_port", 32'(in_port), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    out_strobe = '0; out_port = '0; rd_en = 1'b0; clr_overflow = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] st;
    reset = 1'b1; out_strobe = '0; out_port = '0; ch_enable = 4'hF; rd_en = 1'b0; clr_overflow = 1'b0;
    m_reset();
    @(negedge clk);
    do_reset();

    // Lone capture on channel 1
    step(4'b0010, 32'h0000_0500, 1'b0, 1'b0);
    step(4'b0010, 32'h0000_0500, 1'b0, 1'b0);
    step(4'b0000, 32'h0, 1'b0, 1'b0);
    chk("t1_not_yet", 32'(rd_valid), 32'h0);
    step(4'b0000, 32'h0, 1'b0, 1'b0);
    chk("t1_valid", 32'(rd_valid), 32'h1);
    chk("t1_data", 32'(rd_data), 32'h105);
    chk("t1_in_port", 32'(in_port), 32'h1);
    idle(1, 1'b1);

    // Simultaneous falls on channels 3, 0, 2
    step(4'b1101, 32'h3322_0000, 1'b0, 1'b0);
    idle(5, 1'b0);
    chk("t2_count", 32'(fifo_count), 32'h3);
    chk("t2_in_port", 32'(in_port), 32'h1);
    chk("t2_head0", 32'(rd_data), 32'h000);
    idle(1, 1'b1);
    chk("t2_head1", 32'(rd_data), 32'h222);
    idle(1, 1'b1);
    chk("t2_head2", 32'(rd_data), 32'h333);
    idle(2, 1'b1);

    // Overfill with 17 channel-1 writes
    @(negedge clk);
    do_reset();
    for (int i = 1; i <= 17; i++) pulse1(8'(i), 1'b0);
    idle(2, 1'b0);
    chk("t3_count", 32'(fifo_count), 32'd16);
    chk("t3_overflow", 32'(overflow), 32'h1);
    chk("t3_in_port", 32'(in_port), 32'd16);
    chk("t3_head", 32'(rd_data), 32'h101);
    step(4'b0000, 32'h0, 1'b0, 1'b1);
    chk("t3_clr", 32'(overflow), 32'h0);

    // Full FIFO, push coincides with pop
    step(4'b0010, 32'h0000_AA00, 1'b0, 1'b0);
    step(4'b0000, 32'h0, 1'b0, 1'b0);
    step(4'b0000, 32'h0, 1'b1, 1'b0);
    chk("t4_count", 32'(fifo_count), 32'd16);
    chk("t4_overflow", 32'(overflow), 32'h0);
    idle(15, 1'b1);
    chk("t4_tail", 32'(rd_data), 32'h1AA);
    idle(1, 1'b1);

    // Disabled channel, then reset with entries queued
    ch_enable = 4'b1101;
    pulse1(8'h55, 1'b0);
    idle(2, 1'b0);
    chk("t5_count", 32'(fifo_count), 32'h0);
    chk("t5_in_port", 32'(in_port), 32'd17);
    ch_enable = 4'hF;
    step(4'b0111, 32'h0003_0201, 1'b0, 1'b0);
    idle(5, 1'b0);
    chk("t5_queued", 32'(fifo_count), 32'h3);
    step(4'b0000, 32'h0, 1'b1, 1'b0);
    rd_en = 1'b1;
    do_reset();

    // Stimulus wrap
    for (int i = 0; i < 255; i++) pulse1(8'(i), 1'b1);
    step(4'b0000, 32'h0, 1'b1, 1'b0);
    chk("t6_ff", 32'(in_port), 32'hFF);
    pulse1(8'h77, 1'b1);
    step(4'b0000, 32'h0, 1'b1, 1'b0);
    chk("t6_wrap", 32'(in_port), 32'h00);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      st = '0;
      for (int c = 0; c < 4; c++) st[c] = ($urandom_range(0, 9) < 4);
      ch_enable = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      step(st, $urandom, ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0));
    end
    idle(30, 1'b1);
    chk("final_empty", 32'(fifo_count), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
